pipe_adder: RTL
===============

PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16: operand/result width in bits.
REQ-002 The module SHALL have parameter SEG, default 8: bits added per pipeline stage; STAGES = WIDTH/SEG.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock, all state on the rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port in_valid, input, 1 bit: operands presented.
REQ-006 The module SHALL have port in_ready, output, 1 bit: operands accepted this cycle if in_valid.
REQ-007 The module SHALL have port a, input, WIDTH bits: operand A.
REQ-008 The module SHALL have port b, input, WIDTH bits: operand B.
REQ-009 The module SHALL have port cin, input, 1 bit: carry-in, or borrow-in when sub=1.
REQ-010 The module SHALL have port sub, input, 1 bit: 0 = add, 1 = subtract.
REQ-011 The module SHALL have port out_valid, output, 1 bit: result valid.
REQ-012 The module SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-013 The module SHALL have port s, output, WIDTH bits: sum or difference.
REQ-014 The module SHALL have port cout, output, 1 bit: carry out of the MSB.
REQ-015 The module SHALL have port ovf, output, 1 bit: signed overflow.
REQ-016 The module SHALL have port zero, output, 1 bit: set when s == 0.

Function
REQ-017 Result SHALL be {cout, s} = a + (sub ? ~b : b) + (cin ^ sub), modulo 2^(WIDTH+1).
REQ-018 Stage k SHALL add segment k (bits k*SEG..k*SEG+SEG-1), taking the carry registered by stage k-1; stage 0 uses cin ^ sub.
REQ-019 Operand segments not yet added SHALL be delay-registered alongside the partial result; no combinational carry path SHALL span more than SEG bits.
REQ-020 ovf SHALL equal (carry into MSB) XOR (carry out of MSB); zero SHALL be computed on the final s.
REQ-021 Latency SHALL be exactly STAGES cycles from the accepting edge to out_valid=1, with throughput one operation per cycle.
REQ-022 The pipeline SHALL advance when (out_valid==0 || out_ready==1); in_ready SHALL equal that advance condition, combinationally.
REQ-023 On stall, all stage registers, including s/cout/ovf/zero and out_valid, SHALL hold; no operation SHALL be lost, duplicated or reordered.
REQ-024 Bubbles (in_valid=0 while advancing) SHALL propagate as invalid stages and are not collapsed.
REQ-025 Outputs s, cout, ovf and zero are don't-care while out_valid=0, but SHALL be registered, never combinational from inputs.
REQ-026 If WIDTH % SEG != 0 or SEG < 1, elaboration SHALL fail.

Reset
REQ-027 rst_n=0 SHALL asynchronously clear all stage valid bits, making out_valid=0 and in_ready=1, and SHALL clear s, cout, ovf and zero to 0.
REQ-028 Reset mid-operation SHALL discard all in-flight operations; the first input accepted after rst_n rises SHALL emerge after STAGES cycles.

Configuration
REQ-029 With macro PIPE_ADDER_SAT_EN defined, input port sat (1 bit) SHALL exist and travel with its operation; when sat=1 and ovf=1, s SHALL be 2^(WIDTH-1)-1 if a[MSB]=0, else 2^(WIDTH-1).
REQ-030 When saturating, ovf and cout SHALL still report the raw result, and zero SHALL reflect the saturated s.
REQ-031 Without PIPE_ADDER_SAT_EN, port sat and all saturation logic SHALL be absent and s SHALL always be the wrapped result.

Verification (WIDTH=16, SEG=8, STAGES=2)
REQ-032 a=0x00FF, b=0x0001, cin=0, sub=0 -> after 2 cycles: s=0x0100, cout=0, ovf=0, zero=0 (carry crosses the stage boundary).
REQ-033 a=0xFFFF, b=0x0001, add -> s=0x0000, cout=1, ovf=0, zero=1.
REQ-034 a=0x0005, b=0x0007, sub=1, cin=0 -> s=0xFFFE, cout=0; with cin=1 -> s=0xFFFD.
REQ-035 a=0x7FFF, b=0x0001, add -> s=0x8000, ovf=1; with PIPE_ADDER_SAT_EN and sat=1 -> s=0x7FFF, ovf=1.
REQ-036 Four back-to-back inputs with out_ready=0 for 3 cycles -> in_ready=0 once full, outputs held, then all four results delivered in order with no loss.
REQ-037 Assert rst_n=0 with 2 operations in flight -> out_valid=0 immediately (asynchronously), and no stale result appears after rst_n rises.

Source files
------------

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder.
// The sat signal exists only when PIPE_ADDER_SAT_EN is defined.
interface pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
`ifdef PIPE_ADDER_SAT_EN
    logic             sat;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
`ifdef PIPE_ADDER_SAT_EN
        output sat,
`endif
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf, zero
    );

    modport slave (
`ifdef PIPE_ADDER_SAT_EN
        input  sat,
`endif
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf, zero
    );
endinterface

// File: rtl/pipe_adder.sv
// Segmented pipelined adder/subtractor: rank 0 registers operands, rank k adds segment k-1.
// Optional saturation is enabled by defining PIPE_ADDER_SAT_EN.
module pipe_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 8
) (
    input logic         clk,
    input logic         rst_n,
    pipe_adder_if.slave bus
);
    localparam int SEG_C  = (SEG < 1) ? 1 : SEG;
    localparam int STAGES = WIDTH / SEG_C;

    generate
        if (SEG < 1 || (WIDTH % SEG_C) != 0) begin : g_bad_cfg
            $error("pipe_adder: WIDTH must be a positive multiple of SEG");
        end
    endgenerate

    logic [STAGES:0]   vld_q, vld_d;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [STAGES-1:0] c_q, c_d;
`ifdef PIPE_ADDER_SAT_EN
    logic [STAGES-1:0] sat_q, sat_d;
`endif
    logic [WIDTH-1:0]  s_q, s_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;
    logic              adv;

    always_comb begin
        logic [SEG_C:0]   seg;
        logic [SEG_C:0]   last;
        logic [WIDTH-1:0] raw;
        seg    = '0;
        last   = '0;
        raw    = '0;
        adv    = !vld_q[STAGES] || bus.out_ready;
        vld_d  = vld_q;
        a_d    = a_q;
        b_d    = b_q;
        sum_d  = sum_q;
        c_d    = c_q;
        s_d    = s_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;

        // Subtraction folds into addition: invert b here, carry-in becomes cin ^ sub.
        vld_d[0] = bus.in_valid;
        a_d[0]   = bus.a;
        b_d[0]   = bus.sub ? ~bus.b : bus.b;
        sum_d[0] = '0;
        c_d[0]   = bus.cin ^ bus.sub;
`ifdef PIPE_ADDER_SAT_EN
        sat_d    = sat_q;
        sat_d[0] = bus.sat;
`endif

        for (int r = 1; r < STAGES; r++) begin
            seg = {1'b0, a_q[r-1][(r-1)*SEG_C +: SEG_C]}
                + {1'b0, b_q[r-1][(r-1)*SEG_C +: SEG_C]}
                + {{SEG_C{1'b0}}, c_q[r-1]};
            vld_d[r] = vld_q[r-1];
            a_d[r]   = a_q[r-1];
            b_d[r]   = b_q[r-1];
            sum_d[r] = sum_q[r-1];
            sum_d[r][(r-1)*SEG_C +: SEG_C] = seg[SEG_C-1:0];
            c_d[r]   = seg[SEG_C];
`ifdef PIPE_ADDER_SAT_EN
            sat_d[r] = sat_q[r-1];
`endif
        end

        vld_d[STAGES] = vld_q[STAGES-1];
        last = {1'b0, a_q[STAGES-1][WIDTH-SEG_C +: SEG_C]}
             + {1'b0, b_q[STAGES-1][WIDTH-SEG_C +: SEG_C]}
             + {{SEG_C{1'b0}}, c_q[STAGES-1]};
        raw = sum_q[STAGES-1];
        raw[WIDTH-SEG_C +: SEG_C] = last[SEG_C-1:0];
        cout_d = last[SEG_C];
        // Carry into the MSB is recovered from the MSB sum bit and its two addends.
        ovf_d  = a_q[STAGES-1][WIDTH-1] ^ b_q[STAGES-1][WIDTH-1] ^ raw[WIDTH-1] ^ last[SEG_C];
        s_d    = raw;
`ifdef PIPE_ADDER_SAT_EN
        if (sat_q[STAGES-1] && ovf_d)
            s_d = a_q[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
`endif
        zero_d = (s_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            a_q    <= '{default: '0};
            b_q    <= '{default: '0};
            sum_q  <= '{default: '0};
            c_q    <= '0;
`ifdef PIPE_ADDER_SAT_EN
            sat_q  <= '0;
`endif
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            vld_q  <= vld_d;
            a_q    <= a_d;
            b_q    <= b_d;
            sum_q  <= sum_d;
            c_q    <= c_d;
`ifdef PIPE_ADDER_SAT_EN
            sat_q  <= sat_d;
`endif
            s_q    <= s_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_q[STAGES];
    assign bus.s         = s_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule
